// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw bus, frames 11-bit packets and turns
// make codes into a stable key_in with a key_p strobe; break sequences are swallowed.
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int PULSE_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_p,
    output logic       key_ext,
    output logic       key_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   sync_clk, sync_data, fall;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          err_q, err_d;

    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    key_in_q, key_in_d;
    logic          key_ext_q, key_ext_d;
    logic          key_p_q, key_p_d;
    logic          restart_q, restart_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic          accept;

    // Synchronizers idle high so a reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= sync_clk;
        end
    end

    assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
    assign sync_data = data_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~sync_clk;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_d      = '0;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        err_d      = 1'b0;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sync_data) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d = {sync_data, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                    else bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: begin
                    parity_d = sync_data;
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if ((^{shift_q, parity_q}) && sync_data) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled partial frame is abandoned; the prefix flags survive it.
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else if (tmo_q != '1) begin
                tmo_d = tmo_q + 1'b1;
            end else begin
                tmo_d = tmo_q;
            end
        end
    end

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        key_in_d  = key_in_q;
        key_ext_d = key_ext_q;
        accept    = 1'b0;
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else begin
                accept    = 1'b1;
                key_in_d  = byte_q;
                key_ext_d = ext_q;
                ext_d     = 1'b0;
            end
        end
    end

    // A make that lands mid-pulse forces one low cycle so the controller sees a new edge.
    always_comb begin
        key_p_d     = key_p_q;
        restart_d   = 1'b0;
        pulse_cnt_d = pulse_cnt_q;
        if (accept) begin
            if (key_p_q) begin
                key_p_d   = 1'b0;
                restart_d = 1'b1;
            end else begin
                key_p_d     = 1'b1;
                pulse_cnt_d = PULSE_LAST;
            end
        end else if (restart_q) begin
            key_p_d     = 1'b1;
            pulse_cnt_d = PULSE_LAST;
        end else if (key_p_q) begin
            if (pulse_cnt_q == '0) key_p_d = 1'b0;
            else pulse_cnt_d = pulse_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            err_q       <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_in_q    <= '0;
            key_ext_q   <= 1'b0;
            key_p_q     <= 1'b0;
            restart_q   <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            byte_vld_q  <= byte_vld_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_in_q    <= key_in_d;
            key_ext_q   <= key_ext_d;
            key_p_q     <= key_p_d;
            restart_q   <= restart_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign key_in  = key_in_q;
    assign key_ext = key_ext_q;
    assign key_p   = key_p_q;
    assign key_err = err_q;

endmodule
